decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage; consumes the IF/ID pipeline register (`if_npc`, `if_inst`) and drives the redirect controls back into fetch (`pc_src`, `jump_address`, `branch_address`, `stall`). It holds the 16×32 register file, resolves branches and jumps in decode, detects data hazards, and produces the registered ID/EX pipeline register for the execute stage.

## Interface
- `NREGS`, 16: register count; R0 reads zero, writes to R0 are ignored.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low; clock `clk`
- `if_valid`  in  1  IF/ID holds a real instruction
- `if_npc`  in  32  PC+4 of the IF/ID instruction
- `if_inst`  in  32  instruction word
- `wb_en`, `wb_rd`, `wb_data`  in  1/4/32  writeback port into the register file
- `mem_wb_en`, `mem_rd`  in  1/4  MEM-stage destination, for hazard checks
- `stall`  out  1  hold PC and IF/ID this cycle
- `pc_src`  out  2  0 = PC+4, 1 = jump, 2 = branch
- `jump_address`, `branch_address`  out  32  redirect targets
- `ex_valid`, `ex_op`, `ex_rd`, `ex_wb`, `ex_mem_read`, `ex_mem_write`  out  1/6/4/1/1/1  ID/EX control
- `ex_a`, `ex_b`, `ex_imm`, `ex_npc`  out  32 each  ID/EX data
- `illegal`  out  1  one-cycle pulse on an undefined opcode

## Operation

**Instruction format**
- Fields: `op` = [31:26], `rd` = [25:22], `rs1` = [21:18], `rs2` = [17:14], `imm` = sext([13:0]).
- Opcodes:
  - R-type (reads rs1 and rs2, writes rd): 00 ADD, 01 SUB, 02 AND, 03 OR.
  - 08 ADDI: reads rs1, writes rd.
  - 10 LW: reads rs1, writes rd, sets `mem_read`.
  - 11 SW: reads rs1 and rs2, sets `mem_write`.
  - 20 BEQ and 21 BNE: read rs1 and rs2.
  - 30 J.
  - 3F NOP.
  - Any other opcode: handled as NOP, and `illegal` pulses.

**Register file**
- Written at posedge when `wb_en` is high and `wb_rd` ≠ 0.
- Reads are combinational with write bypass: if `wb_en` and `wb_rd` equals the source register (and is nonzero), the read returns `wb_data`.

**Targets**
- `branch_address` = `if_npc` + (`imm` << 2).
- `jump_address` = `if_npc` + (sext([25:0]) << 2).
- Both are computed every cycle, whether or not a redirect is taken.

**Hazards (`stall`)**
- Stall conditions apply only when the instruction is valid and not squashed, and only for a nonzero source register that the opcode actually reads:
  - Load-use: `ex_valid & ex_mem_read` and `ex_rd` matches a source.
  - Branch operand: BEQ/BNE, and `(ex_valid & ex_wb & ex_rd)` or `(mem_wb_en & mem_rd)` matches rs1 or rs2.
- While stalled:
  - `stall` = 1.
  - `pc_src` = 0.
  - ID/EX receives a bubble (`ex_valid` = 0).
  - No `illegal` pulse.

**Redirect**
- Applies when valid, not squashed and not stalled:
  - J: `pc_src` = 1.
  - BEQ: `pc_src` = 2 when rs1 value equals rs2 value.
  - BNE: `pc_src` = 2 when the values differ.
- Otherwise `pc_src` = 0.

**Squash**
- Internal register `squash` is set at posedge whenever `pc_src` ≠ 0; otherwise it is cleared.
- While `squash` = 1, the IF/ID contents are the wrong-path instruction. It is treated as `if_valid` = 0: no stall, no redirect, bubble, no `illegal`.

**ID/EX register**
- Updated every posedge.
- `ex_valid` = valid & ~squash & ~stall & opcode not NOP/illegal/J/branch.
- Data fields load the decoded values, with `ex_a`/`ex_b` taken from the bypassed reads.
- When `ex_valid` = 0, all control bits are 0; data fields are don't-care.

## Timing
- Reset: every output, the ID/EX register, `squash`, and all register-file entries are 0. Reset is asynchronous: asserting it mid-operation clears state immediately and discards any pending redirect.
- Combinational from IF/ID and ID/EX in the same cycle: `stall`, `pc_src`, the targets and `illegal`.
- ID/EX latency: 1 cycle.
- Taken redirect: fetch loads the target at the next edge. Exactly one wrong-path instruction follows and is squashed, so a taken branch costs 1 cycle.
- Load-use: exactly 1 stall cycle.
- Branch dependent on EX: 2 stall cycles. Branch dependent on MEM: 1 stall cycle.
- Simultaneous writeback and read of the same register: the new value is seen in the same cycle.
- Simultaneous hazard and taken condition: the stall wins, and the branch resolves on a later cycle.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release -> all outputs 0, `ex_valid` = 0, and reading R1..R15 returns 0.
- Bypass: `wb_en` = 1, `wb_rd` = 3, `wb_data` = 0x55, same cycle as ADD r1, r3, r3 -> next cycle `ex_a` = `ex_b` = 0x55, `ex_valid` = 1, `ex_rd` = 1.
- Load-use: LW r2 then ADD r4, r2, r5 -> `stall` = 1 for one cycle with a bubble; then ADD issues. Repeat with r0 as the dependency -> no stall.
- Taken BEQ: r1 = r2 = 7, `if_npc` = 0x100, imm = 3 -> `pc_src` = 2, `branch_address` = 0x10C. Next cycle the instruction is squashed: `ex_valid` = 0 and `pc_src` = 0 even if it is a J.
- BNE not taken (r1 = r2) -> `pc_src` = 0, no squash. J with offset −1 at `if_npc` = 0x20 -> `pc_src` = 1, `jump_address` = 0x1C.
- Opcode 0x15 -> `illegal` pulses for 1 cycle with `ex_valid` = 0. Asserting `rst` while `squash` = 1 -> `squash` = 0 and `pc_src` = 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: register file, branch/jump resolution, hazard
// detection and the registered ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_npc,
  input  logic [31:0] i_if_inst,
  input  logic        i_wb_en,
  input  logic [3:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_mem_wb_en,
  input  logic [3:0]  i_mem_rd,
  output logic        o_stall,
  output logic [1:0]  o_pc_src,
  output logic [31:0] o_jump_address,
  output logic [31:0] o_branch_address,
  output logic        o_ex_valid,
  output logic [5:0]  o_ex_op,
  output logic [3:0]  o_ex_rd,
  output logic        o_ex_wb,
  output logic        o_ex_mem_read,
  output logic        o_ex_mem_write,
  output logic [31:0] o_ex_a,
  output logic [31:0] o_ex_b,
  output logic [31:0] o_ex_imm,
  output logic [31:0] o_ex_npc,
  output logic        o_illegal
);

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h10;
  localparam logic [5:0] OpSw   = 6'h11;
  localparam logic [5:0] OpBeq  = 6'h20;
  localparam logic [5:0] OpBne  = 6'h21;
  localparam logic [5:0] OpJ    = 6'h30;
  localparam logic [5:0] OpNop  = 6'h3F;

  logic [31:0] r_regs [NREGS];
  logic        r_squash;
  logic        r_ex_valid, r_ex_wb, r_ex_mem_read, r_ex_mem_write;
  logic [5:0]  r_ex_op;
  logic [3:0]  r_ex_rd;
  logic [31:0] r_ex_a, r_ex_b, r_ex_imm, r_ex_npc;

  logic [5:0]  w_op;
  logic [3:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm, w_rs1_val, w_rs2_val;
  logic        w_rtype, w_branch, w_known, w_reads1, w_reads2, w_writes;
  logic        w_valid, w_load_use, w_br_haz, w_stall, w_issue;
  logic [1:0]  w_pc_src;

  assign w_op  = i_if_inst[31:26];
  assign w_rd  = i_if_inst[25:22];
  assign w_rs1 = i_if_inst[21:18];
  assign w_rs2 = i_if_inst[17:14];
  assign w_imm = {{18{i_if_inst[13]}}, i_if_inst[13:0]};

  // Opcode classification: which sources are read, whether rd is written.
  always_comb begin
    w_rtype  = (w_op >= OpAdd) && (w_op <= OpOr);
    w_branch = (w_op == OpBeq) || (w_op == OpBne);
    w_writes = w_rtype || (w_op == OpAddi) || (w_op == OpLw);
    w_reads1 = w_writes || (w_op == OpSw) || w_branch;
    w_reads2 = w_rtype || (w_op == OpSw) || w_branch;
    w_known  = w_reads1 || (w_op == OpJ) || (w_op == OpNop);
  end

  // Register file reads with same-cycle writeback bypass; R0 is never written.
  always_comb begin
    w_rs1_val = r_regs[w_rs1];
    w_rs2_val = r_regs[w_rs2];
    if (i_wb_en && (i_wb_rd != 4'd0) && (i_wb_rd == w_rs1)) w_rs1_val = i_wb_data;
    if (i_wb_en && (i_wb_rd != 4'd0) && (i_wb_rd == w_rs2)) w_rs2_val = i_wb_data;
  end

  // Hazard detection and redirect; held quiet while reset is asserted.
  always_comb begin
    w_valid    = i_if_valid && !r_squash && rst;
    w_load_use = r_ex_valid && r_ex_mem_read &&
                 ((w_reads1 && (w_rs1 != 4'd0) && (r_ex_rd == w_rs1)) ||
                  (w_reads2 && (w_rs2 != 4'd0) && (r_ex_rd == w_rs2)));
    w_br_haz   = w_branch &&
                 ((r_ex_valid && r_ex_wb &&
                   (((w_rs1 != 4'd0) && (r_ex_rd == w_rs1)) ||
                    ((w_rs2 != 4'd0) && (r_ex_rd == w_rs2)))) ||
                  (i_mem_wb_en &&
                   (((w_rs1 != 4'd0) && (i_mem_rd == w_rs1)) ||
                    ((w_rs2 != 4'd0) && (i_mem_rd == w_rs2)))));
    w_stall    = w_valid && (w_load_use || w_br_haz);
    w_issue    = w_valid && !w_stall;
    w_pc_src   = 2'd0;
    if (w_issue) begin
      if (w_op == OpJ) w_pc_src = 2'd1;
      else if ((w_op == OpBeq) && (w_rs1_val == w_rs2_val)) w_pc_src = 2'd2;
      else if ((w_op == OpBne) && (w_rs1_val != w_rs2_val)) w_pc_src = 2'd2;
    end
  end

  assign o_stall          = w_stall;
  assign o_pc_src         = w_pc_src;
  assign o_illegal        = w_issue && !w_known;
  assign o_branch_address = rst ? i_if_npc + {w_imm[29:0], 2'b00} : 32'd0;
  assign o_jump_address   = rst ? i_if_npc + {{4{i_if_inst[25]}}, i_if_inst[25:0], 2'b00}
                                : 32'd0;

  // Register file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
    end else if (i_wb_en && (i_wb_rd != 4'd0)) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  // Squash flag and ID/EX pipeline register; bubbles carry no control bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_squash       <= 1'b0;
      r_ex_valid     <= 1'b0;
      r_ex_op        <= 6'd0;
      r_ex_rd        <= 4'd0;
      r_ex_wb        <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_a         <= 32'd0;
      r_ex_b         <= 32'd0;
      r_ex_imm       <= 32'd0;
      r_ex_npc       <= 32'd0;
    end else begin
      r_squash       <= (w_pc_src != 2'd0);
      r_ex_valid     <= w_issue && (w_writes || (w_op == OpSw));
      r_ex_op        <= (w_issue && (w_writes || (w_op == OpSw))) ? w_op : 6'd0;
      r_ex_rd        <= (w_issue && (w_writes || (w_op == OpSw))) ? w_rd : 4'd0;
      r_ex_wb        <= w_issue && w_writes;
      r_ex_mem_read  <= w_issue && (w_op == OpLw);
      r_ex_mem_write <= w_issue && (w_op == OpSw);
      r_ex_a         <= w_rs1_val;
      r_ex_b         <= w_rs2_val;
      r_ex_imm       <= w_imm;
      r_ex_npc       <= i_if_npc;
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_op        = r_ex_op;
  assign o_ex_rd        = r_ex_rd;
  assign o_ex_wb        = r_ex_wb;
  assign o_ex_mem_read  = r_ex_mem_read;
  assign o_ex_mem_write = r_ex_mem_write;
  assign o_ex_a         = r_ex_a;
  assign o_ex_b         = r_ex_b;
  assign o_ex_imm       = r_ex_imm;
  assign o_ex_npc       = r_ex_npc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_npc, if_inst;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_wb_en;
  logic [3:0]  mem_rd;
  logic        stall, ex_valid, ex_wb, ex_mem_read, ex_mem_write, illegal;
  logic [1:0]  pc_src;
  logic [31:0] jump_address, branch_address, ex_a, ex_b, ex_imm, ex_npc;
  logic [5:0]  ex_op;
  logic [3:0]  ex_rd;

  int n_assert = 0;
  int n_fail   = 0;

  decode_stage #(.NREGS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_if_valid       (if_valid),
    .i_if_npc         (if_npc),
    .i_if_inst        (if_inst),
    .i_wb_en          (wb_en),
    .i_wb_rd          (wb_rd),
    .i_wb_data        (wb_data),
    .i_mem_wb_en      (mem_wb_en),
    .i_mem_rd         (mem_rd),
    .o_stall          (stall),
    .o_pc_src         (pc_src),
    .o_jump_address   (jump_address),
    .o_branch_address (branch_address),
    .o_ex_valid       (ex_valid),
    .o_ex_op          (ex_op),
    .o_ex_rd          (ex_rd),
    .o_ex_wb          (ex_wb),
    .o_ex_mem_read    (ex_mem_read),
    .o_ex_mem_write   (ex_mem_write),
    .o_ex_a           (ex_a),
    .o_ex_b           (ex_b),
    .o_ex_imm         (ex_imm),
    .o_ex_npc         (ex_npc),
    .o_illegal        (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [13:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] off);
    return {6'h30, off};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] npc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_npc   = npc;
    if_inst  = inst;
    #1;
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_npc = '0; if_inst = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; mem_wb_en = 1'b0; mem_rd = '0;
    tick(); tick();
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_pc_src", {30'd0, pc_src}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_ex_a", ex_a, 32'd0);
    rst = 1'b1;

    // Register file reads as zero after reset
    for (int k = 1; k < 16; k++) begin
      present(32'h4, enc(6'h00, 4'd0, 4'(k), 4'(k), 14'd0));
      tick();
      check("rst_read_a", ex_a, 32'd0);
      check("rst_read_b", ex_b, 32'd0);
    end

    // Load register contents; R0 write ignored
    if_valid = 1'b0;
    wb_en = 1'b1;
    wb_rd = 4'd1; wb_data = 32'd7;      tick();
    wb_rd = 4'd2; wb_data = 32'd7;      tick();
    wb_rd = 4'd5; wb_data = 32'd9;      tick();
    wb_rd = 4'd0; wb_data = 32'hDEAD;   tick();
    wb_en = 1'b0;
    present(32'h8, enc(6'h00, 4'd0, 4'd0, 4'd1, 14'd0));
    tick();
    check("r0_read", ex_a, 32'd0);
    check("r1_read", ex_b, 32'd7);

    // Writeback bypass into ADD r1, r3, r3
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'h55;
    present(32'hC, enc(6'h00, 4'd1, 4'd3, 4'd3, 14'd0));
    tick();
    wb_en = 1'b0;
    check("byp_ex_a", ex_a, 32'h55);
    check("byp_ex_b", ex_b, 32'h55);
    check("byp_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("byp_ex_rd", {28'd0, ex_rd}, 32'd1);
    check("byp_ex_wb", {31'd0, ex_wb}, 32'd1);

    // Load-use: LW r2, 4(r1) then ADD r4, r2, r5
    present(32'h10, enc(6'h10, 4'd2, 4'd1, 4'd0, 14'd4));
    check("lw_stall", {31'd0, stall}, 32'd0);
    tick();
    check("lw_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    check("lw_ex_imm", ex_imm, 32'd4);
    check("lw_ex_a", ex_a, 32'd7);
    check("lw_ex_npc", ex_npc, 32'h10);
    present(32'h14, enc(6'h00, 4'd4, 4'd2, 4'd5, 14'd0));
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_wb", {31'd0, ex_wb}, 32'd0);
    check("lu_stall_released", {31'd0, stall}, 32'd0);
    tick();
    check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_issue_a", ex_a, 32'd7);
    check("lu_issue_b", ex_b, 32'd9);
    check("lu_issue_rd", {28'd0, ex_rd}, 32'd4);

    // Load to r0 never creates a dependency
    present(32'h18, enc(6'h10, 4'd0, 4'd1, 4'd0, 14'd0));
    tick();
    present(32'h1C, enc(6'h00, 4'd4, 4'd0, 4'd5, 14'd0));
    check("lu_r0_stall", {31'd0, stall}, 32'd0);
    tick();
    check("lu_r0_valid", {31'd0, ex_valid}, 32'd1);

    // Taken BEQ r1, r2 at npc 0x100, imm 3
    present(32'h100, enc(6'h20, 4'd0, 4'd1, 4'd2, 14'd3));
    check("beq_pc_src", {30'd0, pc_src}, 32'd2);
    check("beq_target", branch_address, 32'h10C);
    check("beq_stall", {31'd0, stall}, 32'd0);
    tick();
    check("beq_ex_valid", {31'd0, ex_valid}, 32'd0);
    present(32'h104, enc_j(26'd5));
    check("squash_j_pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    check("squash_ex_valid", {31'd0, ex_valid}, 32'd0);

    // BNE not taken, following instruction not squashed
    present(32'h200, enc(6'h21, 4'd0, 4'd1, 4'd2, 14'd8));
    check("bne_nt_pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    present(32'h204, enc(6'h08, 4'd6, 4'd1, 4'd0, 14'h3FFF));
    tick();
    check("addi_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_op", {26'd0, ex_op}, 32'h8);

    // J with offset -1 at npc 0x20
    present(32'h20, enc_j(26'h3FF_FFFF));
    check("j_pc_src", {30'd0, pc_src}, 32'd1);
    check("j_target", jump_address, 32'h1C);
    tick();
    present(32'h24, enc(6'h00, 4'd9, 4'd1, 4'd1, 14'd0));
    tick();
    check("j_squash_valid", {31'd0, ex_valid}, 32'd0);

    // Branch dependent on EX then MEM: two stall cycles, stall beats taken
    present(32'h2C, enc(6'h00, 4'd7, 4'd1, 4'd2, 14'd0));
    tick();
    present(32'h300, enc(6'h21, 4'd0, 4'd7, 4'd1, 14'd2));
    check("bh_ex_stall", {31'd0, stall}, 32'd1);
    check("bh_ex_pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    mem_wb_en = 1'b1; mem_rd = 4'd7; #1;
    check("bh_mem_stall", {31'd0, stall}, 32'd1);
    check("bh_mem_pc_src", {30'd0, pc_src}, 32'd0);
    tick();
    mem_wb_en = 1'b0; wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'd14; #1;
    check("bh_resolve_stall", {31'd0, stall}, 32'd0);
    check("bh_resolve_pc_src", {30'd0, pc_src}, 32'd2);
    check("bh_resolve_target", branch_address, 32'h308);
    tick();
    wb_en = 1'b0;
    present(32'h304, enc(6'h3F, 4'd0, 4'd0, 4'd0, 14'd0));
    tick();

    // Undefined opcode
    present(32'h400, enc(6'h15, 4'd3, 4'd1, 4'd2, 14'd0));
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    tick();
    check("ill_ex_valid", {31'd0, ex_valid}, 32'd0);
    present(32'h404, enc(6'h3F, 4'd0, 4'd0, 4'd0, 14'd0));
    check("ill_cleared", {31'd0, illegal}, 32'd0);
    tick();

    // Asynchronous reset while squash is set
    present(32'h40, enc_j(26'd4));
    check("rj_pc_src", {30'd0, pc_src}, 32'd1);
    tick();
    present(32'h44, enc_j(26'd4));
    check("rj_squashed", {30'd0, pc_src}, 32'd0);
    rst = 1'b0; #1;
    check("rst_async_pc_src", {30'd0, pc_src}, 32'd0);
    check("rst_async_stall", {31'd0, stall}, 32'd0);
    present(32'h48, enc(6'h00, 4'd8, 4'd1, 4'd1, 14'd0));
    rst = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_regs", ex_a, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
